// File: rtl/regfile_access_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_access_sequencer
//
// Requester-side controller for a two-port register file whose port A is
// shared between the only write path and operand read A. Writebacks are held
// in a small FIFO and retired one per cycle whenever no operand read is granted.
// An operand read that matches a queued writeback address is stalled, so it
// always sees the newest value. Read data from the register file is captured
// into a registered response with valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                   clock (rising edge), async active-high reset
//   req_valid_i/req_ready_o        operand read request handshake
//   req_addr_a_i/req_addr_b_i      operand register addresses
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_data_a_o/rsp_data_b_o      registered operand values
//   wb_valid_i/wb_ready_o          writeback handshake
//   wb_addr_i/wb_data_i            writeback destination and value
//   wb_count_o                     number of queued writebacks
//   rf_address_a_o/rf_address_b_o  register file addresses
//   rf_write_data_o/rf_write_enable_o register file write path (port A)
//   rf_read_data_a_i/rf_read_data_b_i combinational register file read data
// -----------------------------------------------------------------------------
module regfile_access_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int WB_DEPTH   = 4,
  localparam int CNT_W     = $clog2(WB_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_a_o,
  output logic [DATA_WIDTH-1:0] rsp_data_b_o,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [CNT_W-1:0]      wb_count_o,
  output logic [ADDR_WIDTH-1:0] rf_address_a_o,
  output logic [ADDR_WIDTH-1:0] rf_address_b_o,
  output logic [DATA_WIDTH-1:0] rf_write_data_o,
  output logic                  rf_write_enable_o,
  input  logic [DATA_WIDTH-1:0] rf_read_data_a_i,
  input  logic [DATA_WIDTH-1:0] rf_read_data_b_i
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(WB_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WB_DEPTH - 1);

  // Writeback queue storage and bookkeeping
  logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
  logic [WB_DEPTH-1:0]   wb_vld_q, wb_vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Response holding register
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_WIDTH-1:0] rsp_b_q, rsp_b_d;

  logic hazard_s, not_full_s, non_empty_s, rsp_free_s;
  logic grant_s, push_s, pop_s;

  // Hazard: either operand address matches a queued (not just-pushed) entry.
  // Per-entry valid bits avoid modular pointer arithmetic for any depth.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      hazard_s = hazard_s | (wb_vld_q[i] &
                 ((wb_addr_q[i] == req_addr_a_i) | (wb_addr_q[i] == req_addr_b_i)));
    end
  end

  // Full/empty come from the registered count only, so a pop cannot make room
  // for a push in the same cycle.
  assign not_full_s  = (count_q < DEPTH_C);
  assign non_empty_s = (count_q != {CNT_W{1'b0}});
  assign rsp_free_s  = ~rsp_valid_q | rsp_ready_i;

  // A full queue blocks reads so the pending write drains first.
  assign req_ready_o = rsp_free_s & ~hazard_s & not_full_s;
  assign grant_s     = req_valid_i & req_ready_o;
  assign pop_s       = ~grant_s & non_empty_s;
  assign push_s      = wb_valid_i & not_full_s;

  // Port A arbitration: head-of-queue write whenever no read is granted.
  assign rf_address_a_o    = pop_s ? wb_addr_q[rd_ptr_q] : req_addr_a_i;
  assign rf_address_b_o    = req_addr_b_i;
  assign rf_write_data_o   = non_empty_s ? wb_data_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
  assign rf_write_enable_o = pop_s;

  assign wb_ready_o   = not_full_s;
  assign wb_count_o   = count_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_a_o = rsp_a_q;
  assign rsp_data_b_o = rsp_b_q;

  // Next-state for queue pointers, valid bits, count and response register
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wb_vld_d    = wb_vld_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;

    // Pop and push never target the same slot: pop needs non-empty, push
    // needs non-full, and the pointers only coincide when empty or full.
    if (pop_s) begin
      wb_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wb_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new grant overrides the retire of the old response (streaming).
    if (grant_s) begin
      rsp_valid_d = 1'b1;
      rsp_a_d     = rf_read_data_a_i;
      rsp_b_d     = rf_read_data_b_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers; reset discards queued writebacks and any held response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      wb_vld_q    <= {WB_DEPTH{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= {DATA_WIDTH{1'b0}};
      rsp_b_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wb_vld_q    <= wb_vld_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
    end
  end

  // Queue payload storage, written at the tail on push
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= {ADDR_WIDTH{1'b0}};
        wb_data_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      wb_addr_q[wr_ptr_q] <= wb_addr_i;
      wb_data_q[wr_ptr_q] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
module tb_regfile_access_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  req_addr_a, req_addr_b, wb_addr;
  logic [15:0] rsp_a, rsp_b, wb_data;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_count;
  logic [5:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_wdata, rf_rdata_a, rf_rdata_b;
  logic        rf_we;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Behavioural 64 x 16 register file: combinational reads, write on port A
  logic [15:0] rf_mem [64] = '{default: 16'h0000};
  always @(posedge clk) if (rf_we) rf_mem[rf_addr_a] <= rf_wdata;
  assign rf_rdata_a = rf_mem[rf_addr_a];
  assign rf_rdata_b = rf_mem[rf_addr_b];

  regfile_access_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_a_i(req_addr_a), .req_addr_b_i(req_addr_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_a_o(rsp_a), .rsp_data_b_o(rsp_b),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_count_o(wb_count),
    .rf_address_a_o(rf_addr_a), .rf_address_b_o(rf_addr_b),
    .rf_write_data_o(rf_wdata), .rf_write_enable_o(rf_we),
    .rf_read_data_a_i(rf_rdata_a), .rf_read_data_b_i(rf_rdata_b)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && wb_count != 3'd0; k++) cyc();
    total_cnt++; if (wb_count !== 3'd0) $display("FAIL %s drain: wb_count=%0d expected 0", tag, wb_count); else pass_cnt++;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [5:0] b, output logic [15:0] da, output logic [15:0] db);
    req_valid = 1'b1; req_addr_a = a; req_addr_b = b; rsp_ready = 1'b1; wb_valid = 1'b0; #1;
    for (int k = 0; k < 20 && !req_ready; k++) begin cyc(); #1; end
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL read_grant_timeout: req_ready=%b expected 1", req_ready); else pass_cnt++;
    cyc(); req_valid = 1'b0; #1;
    da = rsp_a; db = rsp_b;
  endtask

  task automatic test_reset();
    req_valid = 1'b0; rsp_ready = 1'b1; wb_valid = 1'b0;
    req_addr_a = 6'd0; req_addr_b = 6'd0; wb_addr = 6'd0; wb_data = 16'h0000;
    cyc(); cyc(); #1;
    total_cnt++; if (wb_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", wb_count); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_a !== 16'h0 || rsp_b !== 16'h0) $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp_a, rsp_b); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", rf_we); else pass_cnt++;
    total_cnt++; if (wb_ready !== 1'b1) $display("FAIL reset_wb_ready: got %b expected 1", wb_ready); else pass_cnt++;
    cyc(); rst = 1'b0;
  endtask

  task automatic test_hazard_stall();
    cyc(); wb_valid = 1'b1; wb_addr = 6'd5; wb_data = 16'h1234; #1;
    total_cnt++; if (wb_ready !== 1'b1) $display("FAIL hz_wb_ready: got %b expected 1", wb_ready); else pass_cnt++;
    cyc(); wb_valid = 1'b0; req_valid = 1'b1; req_addr_a = 6'd5; req_addr_b = 6'd5; #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL hz_stall: req_ready=%b expected 0", req_ready); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b1 || rf_addr_a !== 6'd5 || rf_wdata !== 16'h1234) $display("FAIL hz_write: we=%b addr=%0d data=%h expected 1/5/1234", rf_we, rf_addr_a, rf_wdata); else pass_cnt++;
    total_cnt++; if (wb_count !== 3'd1) $display("FAIL hz_count: got %0d expected 1", wb_count); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (req_ready !== 1'b1 || rf_we !== 1'b0) $display("FAIL hz_grant: req_ready=%b we=%b expected 1/0", req_ready, rf_we); else pass_cnt++;
    total_cnt++; if (rf_addr_a !== 6'd5 || rf_addr_b !== 6'd5) $display("FAIL hz_read_addr: got %0d/%0d expected 5/5", rf_addr_a, rf_addr_b); else pass_cnt++;
    cyc(); req_valid = 1'b0; #1;
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_a !== 16'h1234 || rsp_b !== 16'h1234) $display("FAIL hz_rsp: valid=%b data=%h/%h expected 1/1234/1234", rsp_valid, rsp_a, rsp_b); else pass_cnt++;
  endtask

  task automatic test_rsp_hold();
    cyc(); wb_valid = 1'b1; wb_addr = 6'd3; wb_data = 16'h0003;
    cyc(); wb_addr = 6'd7; wb_data = 16'h0007;
    cyc(); wb_valid = 1'b0; #1;
    drain("hold");
    cyc(); req_valid = 1'b1; req_addr_a = 6'd3; req_addr_b = 6'd7; rsp_ready = 1'b0; #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL hold_first_grant: got %b expected 1", req_ready); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_a !== 16'h0003 || rsp_b !== 16'h0007) $display("FAIL hold_stable[%0d]: valid=%b data=%h/%h expected 1/0003/0007", k, rsp_valid, rsp_a, rsp_b); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL hold_blocked[%0d]: req_ready=%b expected 0", k, req_ready); else pass_cnt++;
    end
    cyc(); rsp_ready = 1'b1; #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL hold_release: req_ready=%b expected 1", req_ready); else pass_cnt++;
    cyc(); req_valid = 1'b0; #1;
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_a !== 16'h0003 || rsp_b !== 16'h0007) $display("FAIL hold_stream: valid=%b data=%h/%h expected 1/0003/0007", rsp_valid, rsp_a, rsp_b); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL hold_retire: rsp_valid=%b expected 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic fill_queue(input logic [5:0] base, input string tag);
    for (int i = 0; i < 4; i++) begin
      cyc(); wb_valid = 1'b1; wb_addr = base + 6'(i);
      wb_data = (base == 6'd10) ? 16'(16'(10 + i) << 4) : 16'(16'h0020 + 16'(i));
      req_valid = 1'b1; req_addr_a = 6'd0; req_addr_b = 6'd1; rsp_ready = 1'b1; #1;
      total_cnt++; if (req_ready !== 1'b1 || rf_we !== 1'b0) $display("FAIL %s_read_wins[%0d]: req_ready=%b we=%b expected 1/0", tag, i, req_ready, rf_we); else pass_cnt++;
    end
  endtask

  task automatic test_fill_drain();
    fill_queue(6'd10, "fill");
    cyc(); wb_valid = 1'b0; req_valid = 1'b0; #1;
    total_cnt++; if (wb_count !== 3'd4 || wb_ready !== 1'b0) $display("FAIL fill_full: count=%0d wb_ready=%b expected 4/0", wb_count, wb_ready); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (rf_we !== 1'b1 || rf_addr_a !== 6'(10 + k) || rf_wdata !== 16'(16'(10 + k) << 4) || wb_count !== 3'(4 - k))
        $display("FAIL fill_order[%0d]: we=%b addr=%0d data=%h count=%0d expected 1/%0d/%h/%0d", k, rf_we, rf_addr_a, rf_wdata, wb_count, 10 + k, (10 + k) << 4, 4 - k);
      else pass_cnt++;
      cyc();
    end
    #1;
    total_cnt++; if (wb_count !== 3'd0 || rf_we !== 1'b0) $display("FAIL fill_empty: count=%0d we=%b expected 0/0", wb_count, rf_we); else pass_cnt++;
  endtask

  task automatic test_full_priority();
    logic [15:0] da, db;
    fill_queue(6'd20, "prio");
    cyc(); wb_valid = 1'b0; req_valid = 1'b1; req_addr_a = 6'd0; req_addr_b = 6'd1; #1;
    total_cnt++; if (wb_count !== 3'd4 || req_ready !== 1'b0) $display("FAIL prio_full_block: count=%0d req_ready=%b expected 4/0", wb_count, req_ready); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b1 || rf_addr_a !== 6'd20) $display("FAIL prio_drain_first: we=%b addr=%0d expected 1/20", rf_we, rf_addr_a); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (wb_count !== 3'd3 || req_ready !== 1'b1 || rf_we !== 1'b0) $display("FAIL prio_then_read: count=%0d req_ready=%b we=%b expected 3/1/0", wb_count, req_ready, rf_we); else pass_cnt++;
    cyc(); req_valid = 1'b0; #1;
    drain("prio");
    do_read(6'd20, 6'd21, da, db);
    total_cnt++; if (da !== 16'h0020 || db !== 16'h0021) $display("FAIL prio_no_loss_a: got %h/%h expected 0020/0021", da, db); else pass_cnt++;
    do_read(6'd22, 6'd23, da, db);
    total_cnt++; if (da !== 16'h0022 || db !== 16'h0023) $display("FAIL prio_no_loss_b: got %h/%h expected 0022/0023", da, db); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    cyc(); wb_valid = 1'b1; wb_addr = 6'd2; wb_data = 16'h1111;
    cyc(); wb_valid = 1'b0; #1;
    drain("same");
    cyc(); req_valid = 1'b1; req_addr_a = 6'd2; req_addr_b = 6'd2; rsp_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 6'd2; wb_data = 16'h5555; #1;
    total_cnt++; if (req_ready !== 1'b1 || rf_we !== 1'b0) $display("FAIL same_grant: req_ready=%b we=%b expected 1/0", req_ready, rf_we); else pass_cnt++;
    cyc(); wb_valid = 1'b0; #1;
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_a !== 16'h1111 || rsp_b !== 16'h1111) $display("FAIL same_old_value: valid=%b data=%h/%h expected 1/1111/1111", rsp_valid, rsp_a, rsp_b); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0 || rf_we !== 1'b1 || rf_wdata !== 16'h5555) $display("FAIL same_stall_write: req_ready=%b we=%b data=%h expected 0/1/5555", req_ready, rf_we, rf_wdata); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL same_regrant: req_ready=%b expected 1", req_ready); else pass_cnt++;
    cyc(); req_valid = 1'b0; #1;
    total_cnt++; if (rsp_a !== 16'h5555 || rsp_b !== 16'h5555) $display("FAIL same_new_value: got %h/%h expected 5555/5555", rsp_a, rsp_b); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [5:0]  addrs [3];
    logic [15:0] vals  [3];
    logic [15:0] da, db;
    addrs[0] = 6'd3; addrs[1] = 6'd5; addrs[2] = 6'd7;
    vals[0] = 16'hDEAD; vals[1] = 16'hBEEF; vals[2] = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      cyc(); wb_valid = 1'b1; wb_addr = addrs[i]; wb_data = vals[i];
      req_valid = 1'b1; req_addr_a = 6'd0; req_addr_b = 6'd1; rsp_ready = 1'b1;
    end
    cyc(); wb_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; #1;
    total_cnt++; if (wb_count !== 3'd3 || rsp_valid !== 1'b1) $display("FAIL rstmid_pre: count=%0d rsp_valid=%b expected 3/1", wb_count, rsp_valid); else pass_cnt++;
    rst = 1'b1; #1;
    total_cnt++; if (wb_count !== 3'd0 || rsp_valid !== 1'b0 || rf_we !== 1'b0) $display("FAIL rstmid_clear: count=%0d rsp_valid=%b we=%b expected 0/0/0", wb_count, rsp_valid, rf_we); else pass_cnt++;
    total_cnt++; if (rsp_a !== 16'h0 || rsp_b !== 16'h0) $display("FAIL rstmid_rsp_data: got %h/%h expected 0/0", rsp_a, rsp_b); else pass_cnt++;
    cyc(); cyc(); rst = 1'b0; rsp_ready = 1'b1;
    do_read(6'd3, 6'd7, da, db);
    total_cnt++; if (da !== 16'h0003 || db !== 16'h0007) $display("FAIL rstmid_kept_3_7: got %h/%h expected 0003/0007", da, db); else pass_cnt++;
    do_read(6'd5, 6'd5, da, db);
    total_cnt++; if (da !== 16'h1234 || db !== 16'h1234) $display("FAIL rstmid_kept_5: got %h/%h expected 1234/1234", da, db); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_hazard_stall();
    test_rsp_hold();
    test_fill_drain();
    test_full_priority();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
